// File: rtl/ex_ram_arb_pkg.sv
// Shared types and helpers for the multi-PU shared-RAM arbiter.
// Imported by the arbiter core and the top-level datapath.
package ex_ram_arb_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Index width never collapses to zero, even for a single PU.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ex_rr_arbiter.sv
// Combinational request arbiter: one-hot grant, binary index, next pointer.
// The pointer register itself is held by the instantiating module.
module ex_rr_arbiter
    import ex_ram_arb_pkg::*;
#(
    parameter int PU_COUNT = 7,
    parameter int ARB_MODE = 0,
    parameter int IDX_W    = idx_width(PU_COUNT)
) (
    input  logic [PU_COUNT-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [PU_COUNT-1:0] gnt,
    output logic [IDX_W-1:0]    idx,
    output logic [IDX_W-1:0]    next_ptr,
    output logic                any
);

    localparam bit FIXED = (ARB_MODE == int'(ARB_FIXED));

    always_comb begin
        int               cand;
        int               nxt;
        logic [IDX_W-1:0] sel;
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        nxt      = 0;
        sel      = '0;
        next_ptr = ptr;
        // Walk from the search origin, wrapping at the top lane.
        for (int k = 0; k < PU_COUNT; k++) begin
            cand = FIXED ? k : int'(ptr) + k;
            if (cand >= PU_COUNT) begin
                cand = cand - PU_COUNT;
            end
            sel = IDX_W'(cand);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
        nxt = int'(idx) + 1;
        if (nxt >= PU_COUNT) begin
            nxt = 0;
        end
        if (any && !FIXED) begin
            next_ptr = IDX_W'(nxt);
        end
    end

endmodule

// File: rtl/ex_ram_arbiter.sv
// Shared single-port RAM arbiter: picks one PU per cycle, registers the
// RAM access and routes read data back to the requester after the latency.
module ex_ram_arbiter
    import ex_ram_arb_pkg::*;
#(
    parameter int RAM_WIDTH  = 16,
    parameter int PU_COUNT   = 7,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int ARB_MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PU_COUNT-1:0]            pu_req,
    input  logic [PU_COUNT-1:0]            pu_wr_n_rd,
    input  logic [PU_COUNT*ADDR_WIDTH-1:0] pu_addr,
    input  logic [PU_COUNT*RAM_WIDTH-1:0]  pu_wr_data,
    output logic [PU_COUNT-1:0]            pu_gnt,
    output logic [PU_COUNT-1:0]            pu_rd_valid,
    output logic [RAM_WIDTH-1:0]           pu_rd_data,
    input  logic                           ram_ready,
    output logic                           ram_en,
    output logic                           ram_wr_n_rd,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [RAM_WIDTH-1:0]           ram_wr_data,
    input  logic [RAM_WIDTH-1:0]           ram_rd_data
);

    localparam int IDX_W = idx_width(PU_COUNT);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } ret_t;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      next_ptr;
    logic [IDX_W-1:0]      gnt_idx;
    logic [PU_COUNT-1:0]   arb_gnt;
    logic                  arb_any;
    logic                  can_grant;
    logic                  fire;
    logic                  fire_rd;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [RAM_WIDTH-1:0]  sel_data;
    ret_t                  ret_q [RD_LATENCY+1];

    ex_rr_arbiter #(
        .PU_COUNT (PU_COUNT),
        .ARB_MODE (ARB_MODE),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req      (pu_req),
        .ptr      (rr_ptr),
        .gnt      (arb_gnt),
        .idx      (gnt_idx),
        .next_ptr (next_ptr),
        .any      (arb_any)
    );

    assign can_grant = ram_ready & ~rst;
    assign fire      = can_grant & arb_any;
    assign pu_gnt    = can_grant ? arb_gnt : '0;

    assign sel_wr   = pu_wr_n_rd[gnt_idx];
    assign sel_addr = pu_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = pu_wr_data[gnt_idx*RAM_WIDTH +: RAM_WIDTH];
    assign fire_rd  = fire & ~sel_wr;

    // Pointer only moves on an actual transfer; idle and stalled cycles hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en      <= 1'b0;
            ram_wr_n_rd <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else begin
            ram_en <= fire;
            if (fire) begin
                ram_wr_n_rd <= sel_wr;
                ram_addr    <= sel_addr;
                ram_wr_data <= sel_data;
            end
        end
    end

    // One slot per cycle of flight time, so back-to-back reads never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= RD_LATENCY; s++) begin
                ret_q[s] <= '0;
            end
        end else begin
            ret_q[0] <= {fire_rd, gnt_idx};
            for (int s = 1; s <= RD_LATENCY; s++) begin
                ret_q[s] <= ret_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pu_rd_data <= '0;
        end else if (ret_q[RD_LATENCY-1].vld) begin
            pu_rd_data <= ram_rd_data;
        end
    end

    always_comb begin
        pu_rd_valid = '0;
        if (ret_q[RD_LATENCY].vld) begin
            pu_rd_valid[ret_q[RD_LATENCY].idx] = 1'b1;
        end
    end

endmodule
